// File: rtl/lut_interp_pkg.sv
// Shared defaults, fetch FSM states and address offsets for the LUT interpolator reader side.
// Address wrap-around is selected at build time by LUT_WRAP_EN (see lut_addr_gen).
package lut_interp_pkg;

    localparam int LUT_DATA_W = 8;
    localparam int LUT_ADDR_W = 6;
    localparam int LUT_FRAC_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        CAP,
        OUT
    } fetch_state_t;

    localparam logic [1:0] OFS_0 = 2'd0;
    localparam logic [1:0] OFS_1 = 2'd1;
    localparam logic [1:0] OFS_2 = 2'd2;

endpackage

// File: rtl/lut_addr_gen.sv
// Combinational neighbour address: base + offset, clamped to the top entry by default,
// or taken modulo the table depth when LUT_WRAP_EN is defined (periodic tables).
module lut_addr_gen
    import lut_interp_pkg::*;
#(
    parameter int ADDR_W = LUT_ADDR_W
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [1:0]        offset,
    output logic [ADDR_W-1:0] addr
);

`ifdef LUT_WRAP_EN
    always_comb begin
        addr = base + ADDR_W'(offset);
    end
`else
    logic [ADDR_W:0] sum;

    // A carry out of the index width means we ran past the last table entry.
    always_comb begin
        sum  = {1'b0, base} + (ADDR_W + 1)'(offset);
        addr = sum[ADDR_W] ? {ADDR_W{1'b1}} : sum[ADDR_W-1:0];
    end
`endif

endmodule

// File: rtl/lut_sample_fetcher.sv
// Splits an abscissa into LUT index and fraction, reads LUT[idx], LUT[idx+1], LUT[idx+2]
// from a synchronous ROM and holds the triple under valid/ready. Top-entry behaviour follows LUT_WRAP_EN.
module lut_sample_fetcher
    import lut_interp_pkg::*;
#(
    parameter int DATA_W = LUT_DATA_W,
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int FRAC_W = LUT_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+FRAC_W-1:0] x_in,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        y_1,
    output logic [DATA_W-1:0]        y_2,
    output logic [DATA_W-1:0]        y_3,
    output logic [FRAC_W-1:0]        xlsb
);

    fetch_state_t state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [FRAC_W-1:0] xlsb_q, xlsb_d;
    logic [DATA_W-1:0] y_1_q, y_1_d;
    logic [DATA_W-1:0] y_2_q, y_2_d;
    logic [DATA_W-1:0] y_3_q, y_3_d;
    logic              in_ready_q, in_ready_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              out_valid_q, out_valid_d;

    logic [ADDR_W-1:0] x_idx;
    logic [FRAC_W-1:0] x_frac;
    logic [ADDR_W-1:0] gen_base;
    logic [1:0]        gen_offset;
    logic [ADDR_W-1:0] gen_addr;

    assign x_idx  = x_in[ADDR_W+FRAC_W-1:FRAC_W];
    assign x_frac = x_in[FRAC_W-1:0];

    // The address for the next read is prepared one state ahead, since rom_addr is registered.
    always_comb begin
        gen_base   = idx_q;
        gen_offset = OFS_0;
        case (state_q)
            IDLE:    gen_base   = x_idx;
            RD0:     gen_offset = OFS_1;
            RD1:     gen_offset = OFS_2;
            default: gen_offset = OFS_0;
        endcase
    end

    lut_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .base  (gen_base),
        .offset(gen_offset),
        .addr  (gen_addr)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        xlsb_d      = xlsb_q;
        y_1_d       = y_1_q;
        y_2_d       = y_2_q;
        y_3_d       = y_3_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    idx_d      = x_idx;
                    xlsb_d     = x_frac;
                    rom_en_d   = 1'b1;
                    rom_addr_d = gen_addr;
                    state_d    = RD0;
                end
            end
            RD0: begin
                rom_en_d   = 1'b1;
                rom_addr_d = gen_addr;
                state_d    = RD1;
            end
            // Each capture takes the data returned for the read issued one state earlier.
            RD1: begin
                y_1_d      = rom_data;
                rom_en_d   = 1'b1;
                rom_addr_d = gen_addr;
                state_d    = RD2;
            end
            RD2: begin
                y_2_d   = rom_data;
                state_d = CAP;
            end
            CAP: begin
                y_3_d       = rom_data;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            xlsb_q      <= '0;
            y_1_q       <= '0;
            y_2_q       <= '0;
            y_3_q       <= '0;
            in_ready_q  <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xlsb_q      <= xlsb_d;
            y_1_q       <= y_1_d;
            y_2_q       <= y_2_d;
            y_3_q       <= y_3_d;
            in_ready_q  <= in_ready_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign y_1       = y_1_q;
    assign y_2       = y_2_q;
    assign y_3       = y_3_q;
    assign xlsb      = xlsb_q;

endmodule
